fifo_column_reader: RTL
=======================

Name: fifo_column_reader

Overview:
- Read side of the line-buffer memory: drains FIFO_COMPONENT_COUNT parallel line FIFOs in lockstep, one pixel per FIFO per pop.
- Delivers one vertical pixel column per transfer, tagged with its source-frame x/y coordinate, over a valid/ready handshake.
- Sits between the memory block and the Haar window/integral stage.
- Absorbs the FIFOs' 1-cycle read latency with a 2-entry skid buffer, so it sustains 1 column/cycle when downstream is always ready.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FIFO_COMPONENT_COUNT, 6, number of line FIFOs, which equals the column height N.
- FRAME_WIDTH, 10, columns per frame.
- FRAME_HEIGHT, 10, rows per frame.
- COORD_WIDTH, 16, coordinate output width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_os  in  1  synchronous, active-low reset, sampled on clk rising edge.
- i_fifo_empty  in  N  per-FIFO empty flag.
- i_fifo_data  in  N*DATA_WIDTH  per-FIFO read data. FIFO k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]. Valid 1 cycle after rden.
- o_fifo_rden  out  N  per-FIFO read strobe. All bits always equal.
- o_column  out  N*DATA_WIDTH  output column, same packing as i_fifo_data.
- o_xcoord  out  COORD_WIDTH  x of the column's pixels.
- o_ycoord  out  COORD_WIDTH  y of FIFO 0's pixel. FIFO k holds row y+k.
- o_valid  out  1  column valid.
- i_ready  in  1  downstream accepts.
- o_frame_end  out  1  single-cycle pulse, coincident with the transfer of the last column of a frame.

Behaviour:
- Reset (reset_os==0 at a clk edge):
  - o_fifo_rden=0, o_valid=0, o_frame_end=0, o_column=0, o_xcoord=0, o_ycoord=0.
  - Skid buffer emptied; in-flight read discarded.
  - State=IDLE.
  - Reset wins over any simultaneous event.
- Definitions:
  - all_ready = ~|i_fifo_empty.
  - occ = skid entries held (0..2).
  - inflight = 1 when rden was asserted last cycle.
  - Transfer = o_valid & i_ready.
- Read issue:
  - o_fifo_rden = {N{all_ready & (state!=IDLE or all_ready) & (occ + inflight - pop < 2)}}, where pop = transfer this cycle.
  - Strobes are combinational from registered occ/inflight plus the inputs.
  - Strobes are never issued to a subset of FIFOs.
- Capture: the cycle after rden, i_fifo_data is written into the skid tail with the current read coordinate (rx, ry).
- Output:
  - The skid head drives o_column/o_xcoord/o_ycoord; o_valid = (occ!=0).
  - Output is held stable while o_valid & ~i_ready.
  - Capture and pop in the same cycle leave occ unchanged.
  - Overflow is impossible by construction; the bench asserts it.
- Coordinates:
  - rx/ry advance on each capture.
  - rx wraps FRAME_WIDTH-1 -> 0, and ry increments on that wrap.
  - ry wraps FRAME_HEIGHT-N -> 0, the last row at which a full column exists.
  - The skid entry for rx==FRAME_WIDTH-1 and ry==FRAME_HEIGHT-N carries an end-of-frame tag. o_frame_end = o_valid & i_ready & head_tag.
- FSM:
  - IDLE -> STREAM on the first all_ready.
  - STREAM -> STREAM normally.
  - STREAM -> FLUSH when the end-of-frame column is captured. FLUSH issues no reads.
  - FLUSH -> STREAM when occ==0 and inflight==0, i.e. the last column is accepted.
  - This guarantees no column of frame n+1 precedes frame_end of frame n.
- Latency: first all_ready -> o_valid is 2 cycles (rden cycle, capture cycle).
- Throughput: 1 column/cycle with i_ready held 1 and FIFOs non-empty.
- Boundary conditions:
  - FIFO goes empty: reads pause; the skid drains normally.
  - Empty flag rises in the same cycle as rden: not allowed. rden is gated by the same-cycle empty flag.
  - Reset mid-frame: coordinates return to (0,0). Data already read is lost; upstream must be reset together.

Optional Feature:
- Macro FIFO_COLUMN_READER_STATS_EN.
- Defined:
  - Adds o_stall_count (16 bits), incremented on each o_valid & ~i_ready cycle and saturating at 16'hFFFF.
  - Adds o_frame_count (16 bits), incremented on o_frame_end and wrapping.
  - Both clear on reset.
- Undefined: both ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package holds:
  - The pixel type (DATA_WIDTH) and coordinate type (COORD_WIDTH).
  - The FSM state enum {IDLE, STREAM, FLUSH}.
  - The FIFO_COMPONENT_COUNT default.
- Sub-module column_skid_buffer: 2-entry register FIFO carrying {column, x, y, eof_tag}, with push, pop, occ, head outputs.
- The top module holds the FSM, coordinate counters and read-issue logic.

Test Plan:
- Streaming: reset, FIFOs preloaded and never empty, i_ready=1, FIFO k data = 10*k + x.
  - First o_valid on cycle 2 after release.
  - Columns {x, 10+x, ..., 50+x} in order, x=0..9.
  - One transfer per cycle.
- Frame end (10x10, N=6):
  - o_frame_end pulses exactly on column (9,4), the 50th transfer.
  - Next transfer is (0,0).
  - rden=0 during FLUSH.
- Backpressure: i_ready low for 5 cycles mid-row.
  - o_column/o_xcoord held stable.
  - rden stops after occ=2.
  - No loss or duplication on resume.
  - Stats build: o_stall_count=5.
- Starvation: FIFO 3 empty for 4 cycles.
  - No rden to any FIFO.
  - o_valid drops after the skid drains.
  - Sequence continues with no gap in x.
- Reset mid-frame at (6,2) with o_valid=1.
  - All outputs 0 the next cycle.
  - After refill, the first column is tagged (0,0).
- Random i_ready (50%) over 3 frames versus a scoreboard model.
  - Data and coordinates exact.
  - 3 frame_end pulses.
  - Stats build: o_frame_count=3.

Source files
------------

// File: rtl/fifo_column_reader_pkg.sv
// Shared types and defaults for the line-buffer column reader.
// Optional statistics counters are enabled with FIFO_COLUMN_READER_STATS_EN.
package fifo_column_reader_pkg;

  localparam int unsigned PixelWidth            = 8;
  localparam int unsigned CoordWidth            = 16;
  localparam int unsigned FifoComponentCountDef = 6;

  typedef logic [PixelWidth-1:0] pixel_t;
  typedef logic [CoordWidth-1:0] coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } state_e;

endpackage

// File: rtl/column_skid_buffer.sv
// Two-entry register FIFO that absorbs the line FIFOs' read latency.
// Each entry carries {column, x, y, eof_tag} as one flat word.
module column_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] e0_q, e0_d;
  logic [Width-1:0] e1_q, e1_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = data_i;
        else               e1_d = data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push and pop keeps occupancy; only the contents shift.
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = data_i;
        end else begin
          e0_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head_o = e0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_column_reader.sv
// Drains N line FIFOs in lockstep and emits coordinate-tagged pixel columns.
// Define FIFO_COLUMN_READER_STATS_EN to add stall and frame counters.
module fifo_column_reader
  import fifo_column_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = PixelWidth,
  parameter int unsigned FIFO_COMPONENT_COUNT = FifoComponentCountDef,
  parameter int unsigned FRAME_WIDTH          = 10,
  parameter int unsigned FRAME_HEIGHT         = 10,
  parameter int unsigned COORD_WIDTH          = CoordWidth
) (
  input  logic                                       clk,
  input  logic                                       reset_os,
  input  logic [FIFO_COMPONENT_COUNT-1:0]            i_fifo_empty,
  input  logic [FIFO_COMPONENT_COUNT*DATA_WIDTH-1:0] i_fifo_data,
  output logic [FIFO_COMPONENT_COUNT-1:0]            o_fifo_rden,
  output logic [FIFO_COMPONENT_COUNT*DATA_WIDTH-1:0] o_column,
  output logic [COORD_WIDTH-1:0]                     o_xcoord,
  output logic [COORD_WIDTH-1:0]                     o_ycoord,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic                                       o_frame_end
`ifdef FIFO_COLUMN_READER_STATS_EN
  ,
  output logic [15:0]                                o_stall_count,
  output logic [15:0]                                o_frame_count
`endif
);

  localparam int unsigned ColWidth   = FIFO_COMPONENT_COUNT * DATA_WIDTH;
  localparam int unsigned EntryWidth = ColWidth + 2 * COORD_WIDTH + 1;
  localparam logic [COORD_WIDTH-1:0] XLast = COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YLast = COORD_WIDTH'(FRAME_HEIGHT - FIFO_COMPONENT_COUNT);

  state_e                 state_q, state_d;
  logic                   inflight_q, inflight_d;
  logic [COORD_WIDTH-1:0] rx_q, rx_d;
  logic [COORD_WIDTH-1:0] ry_q, ry_d;

  logic                  all_ready;
  logic                  rden;
  logic                  pop;
  logic                  at_eof;
  logic                  eof_cap;
  logic [1:0]            occ;
  logic [EntryWidth-1:0] push_entry;
  logic [EntryWidth-1:0] head;

  assign all_ready = ~|i_fifo_empty;
  assign at_eof    = (rx_q == XLast) && (ry_q == YLast);
  assign eof_cap   = inflight_q && at_eof;
  assign o_valid   = (occ != 2'd0);
  assign pop       = o_valid && i_ready;

  assign push_entry = {i_fifo_data, rx_q, ry_q, at_eof};

  column_skid_buffer #(
    .Width (EntryWidth)
  ) u_skid (
    .clk_i  (clk),
    .rst_ni (reset_os),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i (push_entry),
    .head_o (head),
    .occ_o  (occ)
  );

  assign o_column    = head[EntryWidth-1 -: ColWidth];
  assign o_xcoord    = head[2*COORD_WIDTH -: COORD_WIDTH];
  assign o_ycoord    = head[COORD_WIDTH -: COORD_WIDTH];
  assign o_frame_end = pop && head[0];

  // Read coordinate advances once per captured column.
  always_comb begin
    rx_d       = rx_q;
    ry_d       = ry_q;
    inflight_d = rden;
    if (inflight_q) begin
      if (rx_q == XLast) begin
        rx_d = '0;
        ry_d = (ry_q == YLast) ? '0 : ry_q + COORD_WIDTH'(1);
      end else begin
        rx_d = rx_q + COORD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_os) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      rx_q       <= '0;
      ry_q       <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (all_ready) state_d = StStream;
      StStream: if (eof_cap) state_d = StFlush;
      StFlush:  if ((occ == 2'd0) && !inflight_q) state_d = StStream;
      default:  state_d = StIdle;
    endcase
  end

  // No reads while the end-of-frame column is landing or draining, so frames never interleave.
  always_comb begin
    rden = 1'b0;
    if (reset_os && all_ready && (state_q != StFlush) && !eof_cap) begin
      rden = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    end
    o_fifo_rden = {FIFO_COMPONENT_COUNT{rden}};
  end

`ifdef FIFO_COLUMN_READER_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] frame_q, frame_d;

  always_comb begin
    stall_d = stall_q;
    if (o_valid && !i_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    frame_d = frame_q + {15'd0, o_frame_end};
  end

  always_ff @(posedge clk) begin
    if (!reset_os) begin
      stall_q <= 16'd0;
      frame_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      frame_q <= frame_d;
    end
  end

  assign o_stall_count = stall_q;
  assign o_frame_count = frame_q;
`endif

endmodule
